fetch_stage: RTL and testbench

F stage of the 5-stage MIPS pipeline.
- Holds the PC register and the F/D pipeline register.
- Selects the next PC from the redirect request decoded in D: sequential, beq, j/jal or jr, with one architectural delay slot.
- Consumes `stall` from the stall unit and feeds `D_instr` back to it and to the D-stage decoder.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// F stage of the 5-stage MIPS pipeline: PC register, next-PC select and F/D register.
// Optional FETCH_STALL_CNT_EN adds a free-running stall-cycle counter on stall_cycles.
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  D_npc_sel,
   input  logic        D_br_taken,
   input  logic [31:0] D_rs_data,
   input  logic [31:0] im_instr,
   output logic [31:0] im_addr,
   output logic [31:0] F_pc,
   output logic [31:0] D_instr,
   output logic [31:0] D_pc,
   output logic [31:0] D_pc8,
   output logic        D_valid,
   output logic [31:0] stall_cycles
);

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BEQ = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   // 33-bit bounds so the end of the window cannot wrap.
   localparam logic [32:0] IM_BASE = {1'b0, PC_RESET};
   localparam logic [32:0] IM_END  = IM_BASE + 33'(IM_WORDS) * 33'd4;

   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] npc;
   logic [31:0] fetch_word;
   logic        fetch_ok;

   assign pc_plus4  = F_pc + 32'd4;
   assign br_offset = {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
   assign br_target = D_pc + 32'd4 + br_offset;
   assign j_target  = {D_pc[31:28], D_instr[25:0], 2'b00};

   always_comb begin
      npc = pc_plus4;
      if (D_valid) begin
         case (D_npc_sel)
            NPC_SEQ: npc = pc_plus4;
            NPC_BEQ: npc = D_br_taken ? br_target : pc_plus4;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = D_rs_data;
            default: npc = pc_plus4;
         endcase
      end
   end

   // Misaligned or out-of-window fetches become nops; D_pc still records F_pc.
   assign fetch_ok   = (F_pc[1:0] == 2'b00) &&
                       ({1'b0, F_pc} >= IM_BASE) &&
                       ({1'b0, F_pc} < IM_END);
   assign fetch_word = fetch_ok ? im_instr : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         F_pc    <= PC_RESET;
         D_instr <= 32'h0;
         D_pc    <= PC_RESET;
         D_valid <= 1'b0;
      end else if (!stall) begin
         F_pc    <= npc;
         D_instr <= fetch_word;
         D_pc    <= F_pc;
         D_valid <= 1'b1;
      end
   end

   assign im_addr = F_pc;
   assign D_pc8   = D_pc + 32'd8;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= 32'h0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural pipeline model checked every cycle,
// plus hand-computed literal expectations along a scripted program walk.
module tb_fetch_stage;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam int unsigned IM_WORDS = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  D_npc_sel;
   logic        D_br_taken;
   logic [31:0] D_rs_data;
   logic [31:0] im_instr;
   logic [31:0] im_addr;
   logic [31:0] F_pc;
   logic [31:0] D_instr;
   logic [31:0] D_pc;
   logic [31:0] D_pc8;
   logic        D_valid;
   logic [31:0] stall_cycles;

   int n_vec  = 0;
   int n_miss = 0;

   fetch_stage #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .D_npc_sel    (D_npc_sel),
      .D_br_taken   (D_br_taken),
      .D_rs_data    (D_rs_data),
      .im_instr     (im_instr),
      .im_addr      (im_addr),
      .F_pc         (F_pc),
      .D_instr      (D_instr),
      .D_pc         (D_pc),
      .D_pc8        (D_pc8),
      .D_valid      (D_valid),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   // Program image: jal 0x3040 at 0x3000, beq +3 at 0x3004, beq -4 at 0x3010;
   // every other address (legal or not) returns a nonzero address-tagged word.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_3000: return 32'h0C00_0C10;
         32'h0000_3004: return 32'h1000_0003;
         32'h0000_3010: return 32'h1000_FFFC;
         default:       return {16'h2400, a[15:0]};
      endcase
   endfunction

   assign im_instr = imem_word(im_addr);

   function automatic int cnt_exp(input int n);
`ifdef FETCH_STALL_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   // Behavioural model of the architectural state.
   logic [31:0] m_fpc, m_dinstr, m_dpc, m_cnt;
   logic        m_valid;
   logic        m_known = 1'b0;

   function automatic logic [31:0] m_fetch(input logic [31:0] a);
      longint addr, lo, hi;
      addr = longint'(a);
      lo   = longint'(PC_RESET);
      hi   = lo + 4 * longint'(IM_WORDS);
      if ((addr % 4 == 0) && addr >= lo && addr < hi) return imem_word(a);
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_next(input logic [1:0] sel, input logic tk,
                                          input logic [31:0] rs);
      int          off;
      logic [31:0] seq;
      seq = m_fpc + 32'd4;
      if (!m_valid) return seq;
      if (sel == 2'd1) begin
         off = int'($signed(m_dinstr[15:0]));
         return tk ? (m_dpc + 32'd4 + 32'(off * 4)) : seq;
      end
      if (sel == 2'd2) return (m_dpc & 32'hF000_0000) | (32'(m_dinstr[25:0]) * 32'd4);
      if (sel == 2'd3) return rs;
      return seq;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_fpc    <= PC_RESET;
         m_dinstr <= 32'h0;
         m_dpc    <= PC_RESET;
         m_valid  <= 1'b0;
         m_cnt    <= 32'h0;
         m_known  <= 1'b1;
      end else begin
         if (!stall) begin
            m_fpc    <= m_next(D_npc_sel, D_br_taken, D_rs_data);
            m_dinstr <= m_fetch(m_fpc);
            m_dpc    <= m_fpc;
            m_valid  <= 1'b1;
         end else begin
            m_cnt <= m_cnt + 32'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_known) begin
         chk("im_addr", im_addr, m_fpc);
         chk("F_pc", F_pc, m_fpc);
         chk("D_instr", D_instr, m_dinstr);
         chk("D_pc", D_pc, m_dpc);
         chk("D_pc8", D_pc8, m_dpc + 32'd8);
         chk("D_valid", 32'(D_valid), 32'(m_valid));
         chk("stall_cycles", stall_cycles, 32'(cnt_exp(int'(m_cnt))));
      end
   end

   task automatic step(input logic s, input logic [1:0] sel, input logic tk,
                       input logic [31:0] rs);
      stall      = s;
      D_npc_sel  = sel;
      D_br_taken = tk;
      D_rs_data  = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0; D_npc_sel = 2'b00; D_br_taken = 1'b0; D_rs_data = 32'h0;
      step(0, 2'b00, 0, 0);
      step(1, 2'b11, 0, 32'h5000);
      chk("rst F_pc", F_pc, 32'h3000);
      chk("rst D_pc", D_pc, 32'h3000);
      chk("rst D_valid", 32'(D_valid), 32'h0);
      chk("rst stall_cycles", stall_cycles, 32'h0);
      reset = 1'b0;

      // stalled first cycle with a redirect request: nothing moves, D stays invalid
      step(1, 2'b11, 0, 32'h5000);
      chk("first stall D_valid", 32'(D_valid), 32'h0);
      chk("first stall F_pc", F_pc, 32'h3000);
      chk("first stall cnt", stall_cycles, 32'(cnt_exp(1)));
      repeat (3) step(0, 2'b00, 0, 0);
      chk("free D_pc", D_pc, 32'h3008);
      chk("free F_pc", F_pc, 32'h300C);
      chk("free D_valid", 32'(D_valid), 32'h1);

      repeat (3) step(1, 2'b00, 0, 0);
      chk("hold F_pc", F_pc, 32'h300C);
      chk("hold D_pc", D_pc, 32'h3008);
      chk("hold D_instr", D_instr, 32'h2400_3008);
      chk("hold cnt", stall_cycles, 32'(cnt_exp(4)));

      // jr back to 0x3000, then jal with delay slot
      step(0, 2'b11, 0, 32'h3000);
      chk("jr F_pc", F_pc, 32'h3000);
      chk("jr slot D_pc", D_pc, 32'h300C);
      step(0, 2'b00, 0, 0);
      chk("jal D_pc8", D_pc8, 32'h3008);
      step(0, 2'b10, 0, 0);
      chk("jal F_pc", F_pc, 32'h3040);
      chk("jal slot D_pc", D_pc, 32'h3004);

      // beq +3 at 0x3004 taken
      step(0, 2'b01, 1, 0);
      chk("beq fwd F_pc", F_pc, 32'h3014);
      step(0, 2'b00, 0, 0);
      chk("beq fwd D_pc", D_pc, 32'h3014);

      // beq -4 at 0x3010: stalled first, then taken
      step(0, 2'b11, 0, 32'h3010);
      step(0, 2'b00, 0, 0);
      step(1, 2'b01, 1, 0);
      chk("beq stalled F_pc", F_pc, 32'h3014);
      step(0, 2'b01, 1, 0);
      chk("beq back F_pc", F_pc, 32'h3004);
      step(0, 2'b00, 0, 0);
      step(0, 2'b01, 0, 0);
      chk("beq not taken F_pc", F_pc, 32'h300C);

      // jr held under stall, then out-of-range fetch
      repeat (2) step(1, 2'b11, 0, 32'h7000);
      chk("jr stalled F_pc", F_pc, 32'h300C);
      step(0, 2'b11, 0, 32'h7000);
      chk("jr oor F_pc", F_pc, 32'h7000);
      step(0, 2'b00, 0, 0);
      chk("oor D_instr", D_instr, 32'h0);
      chk("oor D_pc", D_pc, 32'h7000);

      step(0, 2'b11, 0, 32'h3002);
      step(0, 2'b00, 0, 0);
      chk("misaligned D_instr", D_instr, 32'h0);
      chk("misaligned D_pc", D_pc, 32'h3002);

      step(0, 2'b11, 0, 32'h6FFC);
      step(0, 2'b00, 0, 0);
      chk("last word D_instr", D_instr, 32'h2400_6FFC);

      step(0, 2'b11, 0, 32'h2FFC);
      step(0, 2'b00, 0, 0);
      chk("below base D_instr", D_instr, 32'h0);

      step(0, 2'b11, 0, 32'hFFFF_FFFC);
      step(0, 2'b00, 0, 0);
      chk("wrap F_pc", F_pc, 32'h0);
      chk("top D_instr", D_instr, 32'h0);
      step(0, 2'b00, 0, 0);
      chk("wrap D_pc8", D_pc8, 32'h8);
      chk("wrap D_instr", D_instr, 32'h0);

      // reset with stall and redirect asserted
      reset = 1'b1;
      step(1, 2'b11, 0, 32'h1234);
      chk("rst2 F_pc", F_pc, 32'h3000);
      chk("rst2 D_valid", 32'(D_valid), 32'h0);
      chk("rst2 cnt", stall_cycles, 32'h0);
      reset = 1'b0;
      step(0, 2'b00, 0, 0);
      chk("rst2 D_pc", D_pc, 32'h3000);
      chk("rst2 D_instr", D_instr, 32'h0C00_0C10);
      step(0, 2'b00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
